// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// sequencer state encoding and the default iteration count.
package muldiv_pkg;

  localparam int ITERATIONS = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring
// divide step, chosen by is_div. acc is the upper half, work the lower half.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITERATIONS
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] work_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum       = {1'b0, acc} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted   = {acc, work[WIDTH-1]};
    // The extra top bit of trial is the borrow of the trial subtraction.
    trial     = {1'b0, shifted} - {2'b00, opnd};
    acc_next  = sum[WIDTH:1];
    work_next = {sum[0], work[WIDTH-1:1]};
    if (is_div) begin
      if (trial[WIDTH+1]) begin
        acc_next  = WIDTH'(shifted);
        work_next = {work[WIDTH-2:0], 1'b0};
      end else begin
        acc_next  = WIDTH'(trial);
        work_next = {work[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer holding the architectural HI/LO
// registers; operands are made unsigned up front and signs fixed at the end.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITERATIONS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   acc_step, work_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               neg_a, neg_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .acc       (acc_q),
    .work      (work_q),
    .opnd      (opnd_q),
    .acc_next  (acc_step),
    .work_next (work_step)
  );

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;

    neg_a    = op_is_signed(op) & a[WIDTH-1];
    neg_b    = op_is_signed(op) & b[WIDTH-1];
    abs_a    = neg_a ? -a : a;
    abs_b    = neg_b ? -b : b;
    prod_fix = neg_res_q ? -{acc_q, work_q} : {acc_q, work_q};
    quot_fix = neg_res_q ? -work_q : work_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          is_div_d  = op_is_div(op);
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          dz_d      = op_is_div(op) && (b == '0);
          // Multiply shifts the multiplier (b) out of work; divide shifts the dividend (a).
          work_d    = op_is_div(op) ? abs_a : abs_b;
          opnd_d    = op_is_div(op) ? abs_b : abs_a;
          acc_d     = '0;
          cnt_d     = '0;
        end else begin
          if (hi_wr) hi_d = wdata;
          if (lo_wr) lo_d = wdata;
        end
      end
      ST_RUN: begin
        acc_d  = acc_step;
        work_d = work_step;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (!dz_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign div_zero = (state_q == ST_DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random operations
// compared against an arithmetic reference model of HI/LO.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_wr, lo_wr;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  logic [W-1:0] exp_q[$];

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: plain arithmetic on the architectural result.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic ez);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ez = 1'b0;
    case (o)
      2'd0: begin
        p = {32'b0, av} * {32'b0, bv};
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      2'd1: begin
        p = 64'(sa * sb);
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      2'd2: begin
        if (bv == 0) ez = 1'b1;
        else begin lo_m = av / bv; hi_m = av % bv; end
      end
      default: begin
        if (bv == 0) ez = 1'b1;
        else begin
          p = 64'(sa / sb); lo_m = p[31:0];
          p = 64'(sa % sb); hi_m = p[31:0];
        end
      end
    endcase
    exp_q.push_back(hi_m);
    exp_q.push_back(lo_m);
  endtask

  // driver: one operation from IDLE to IDLE, called and returning at a negedge
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit poke, input bit lo_wr_too);
    logic         ez, dz_seen;
    logic [W-1:0] eh, el, hi0, lo0;
    int           edges, seen_at, ndone, nbusy, unstable, dz_bad;
    model_op(o, av, bv, ez);
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; a = av; b = bv;
    lo_wr = lo_wr_too; wdata = $urandom;
    @(posedge clk); edges = 1;
    @(negedge clk);
    start = 1'b0; lo_wr = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    ndone = 0; seen_at = 0; nbusy = 0; unstable = 0; dz_bad = 0; dz_seen = 1'b0;
    while (busy && edges < 80) begin
      nbusy++;
      if (done) begin
        ndone++; seen_at = edges; dz_seen = div_zero;
      end else begin
        if (div_zero) dz_bad++;
        if (hi !== hi0 || lo !== lo0) unstable++;
      end
      if (poke && edges == 5) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        hi_wr = 1'b1; wdata = $urandom;
      end else begin
        start = 1'b0; hi_wr = 1'b0;
      end
      @(posedge clk); edges++;
      @(negedge clk);
    end
    start = 1'b0; hi_wr = 1'b0;
    check({tag, "_latency"}, 64'(seen_at), 64'd34);
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd34);
    check({tag, "_div_zero"}, 64'(dz_seen), 64'(ez));
    check({tag, "_div_zero_idle"}, 64'(dz_bad), 64'd0);
    check({tag, "_hilo_stable"}, 64'(unstable), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  task automatic mt(input bit to_hi, input logic [W-1:0] d);
    hi_wr = to_hi; lo_wr = !to_hi; wdata = d;
    @(posedge clk);
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    if (to_hi) begin
      hi_m = d;
      check("mthi", 64'(hi), 64'(hi_m));
    end else begin
      lo_m = d;
      check("mtlo", 64'(lo), 64'(lo_m));
    end
  endtask

  task automatic reset_mid_op();
    int ndone;
    start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(ndone), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_neg3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("div_neg7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_min_sq", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    mt(1'b1, 32'h0000_1234);
    run_op("divu_by_zero", 2'd2, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("start_ignored", 2'd0, $urandom, $urandom, 1'b1, 1'b0);
    run_op("start_beats_mtlo", 2'd2, 32'd9, 32'd0, 1'b0, 1'b1);
    run_op("div_by_zero_s", 2'd3, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0);
    reset_mid_op();
    run_op("after_reset", 2'd1, 32'd12345, 32'hFFFF_FF00, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) mt($urandom_range(0, 1) == 1, $urandom);
      run_op("rand", ro, ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
